// File: rtl/decrom_pkg.sv
// Shared definitions for the decode-pROM consumer: field layout of the
// 36-bit ROM word, the marker for unimplemented slots, the opcode-to-index
// mapping and the unpacked entry handed to the microsequencer.
package decrom_pkg;

    localparam int UA_W = 12;

    // Micro-entry address stored in ROM slots that have no implementation.
    localparam logic [UA_W-1:0] ILLEGAL_UA = 12'h03B;

    // Bit positions inside the 36-bit ROM word.
    localparam int UA1_MSB = 35;
    localparam int UA1_LSB = 24;
    localparam int UA2_MSB = 23;
    localparam int UA2_LSB = 12;
    localparam int FLG_MSB = 11;
    localparam int FLG_LSB = 0;

    typedef struct packed {
        logic [UA_W-1:0] ua1;
        logic [UA_W-1:0] ua2;
        logic [11:0]     flags;
        logic            illegal;
        logic            linea;
        logic            linef;
        logic [15:0]     opcode;
    } dec_entry_t;

    // ROM index: opcode line plus the two size/mode bit pairs.
    function automatic logic [7:0] dec_index(input logic [15:0] op);
        return {op[15:12], op[7:6], op[5:4]};
    endfunction

    // Unpack one ROM word; line A/F come from the opcode, illegal from the ROM.
    function automatic dec_entry_t make_entry(input logic [35:0] word,
                                              input logic [15:0] op);
        dec_entry_t e;
        e.ua1     = word[UA1_MSB:UA1_LSB];
        e.ua2     = word[UA2_MSB:UA2_LSB];
        e.flags   = word[FLG_MSB:FLG_LSB];
        e.illegal = (e.ua1 == ILLEGAL_UA) && (e.ua2 == '0);
        e.linea   = (op[15:12] == 4'hA);
        e.linef   = (op[15:12] == 4'hF);
        e.opcode  = op;
        return e;
    endfunction

endpackage

// File: rtl/decrom_lookup.sv
// Consumer side of the decode pROM. Stage A holds an opcode whose ROM read
// is in flight; stage B holds the unpacked entry offered to the sequencer.
// The ROM clock enable is only raised on accept, so a stalled stage A keeps
// its data sitting on rom_dout until stage B frees up.
module decrom_lookup
    import decrom_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      opcode,
    input  logic             flush,
    output logic [7:0]       rom_ad,
    output logic             rom_ce,
    output logic             rom_oce,
    output logic             rom_reset,
    input  logic [35:0]      rom_dout,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [UA_W-1:0]  dec_ua1,
    output logic [UA_W-1:0]  dec_ua2,
    output logic [11:0]      dec_flags,
    output logic             dec_illegal,
    output logic             dec_linea,
    output logic             dec_linef,
    output logic [15:0]      dec_opcode
);

    logic       a_valid_q, a_valid_d;
    logic [15:0] a_op_q,   a_op_d;
    logic       b_valid_q, b_valid_d;
    dec_entry_t b_q,       b_d;

    logic b_free;
    logic accept;
    logic xfer;

    // Handshakes and next state for both stages; flush overrides everything.
    always_comb begin
        b_free    = !b_valid_q || dec_ready;
        op_ready  = !reset && !flush && (!a_valid_q || b_free);
        accept    = op_valid && op_ready;
        xfer      = a_valid_q && b_free;

        a_valid_d = accept || (a_valid_q && !b_free);
        a_op_d    = accept ? opcode : a_op_q;
        b_valid_d = xfer || (b_valid_q && !dec_ready);
        b_d       = b_q;

        if (xfer && !flush) begin
            b_d = make_entry(rom_dout, a_op_q);
        end

        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            a_op_q    <= '0;
            b_valid_q <= 1'b0;
            b_q       <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_op_q    <= a_op_d;
            b_valid_q <= b_valid_d;
            b_q       <= b_d;
        end
    end

    assign rom_ad      = dec_index(opcode);
    assign rom_ce      = accept;
    assign rom_oce     = 1'b1;
    assign rom_reset   = reset;

    assign dec_valid   = b_valid_q;
    assign dec_ua1     = b_q.ua1;
    assign dec_ua2     = b_q.ua2;
    assign dec_flags   = b_q.flags;
    assign dec_illegal = b_q.illegal;
    assign dec_linea   = b_q.linea;
    assign dec_linef   = b_q.linef;
    assign dec_opcode  = b_q.opcode;

endmodule

// File: tb/tb_decrom_lookup.sv
// Scoreboard bench for decrom_lookup with a synchronous pROM model.
module tb_decrom_lookup;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] opcode;
    logic        flush;
    logic [7:0]  rom_ad;
    logic        rom_ce;
    logic        rom_oce;
    logic        rom_reset;
    logic [35:0] rom_dout = '0;
    logic        dec_valid;
    logic        dec_ready;
    logic [11:0] dec_ua1;
    logic [11:0] dec_ua2;
    logic [11:0] dec_flags;
    logic        dec_illegal;
    logic        dec_linea;
    logic        dec_linef;
    logic [15:0] dec_opcode;

    always #5 clk = ~clk;

    decrom_lookup dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .flush(flush), .rom_ad(rom_ad), .rom_ce(rom_ce),
        .rom_oce(rom_oce), .rom_reset(rom_reset), .rom_dout(rom_dout),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_ua1(dec_ua1),
        .dec_ua2(dec_ua2), .dec_flags(dec_flags), .dec_illegal(dec_illegal),
        .dec_linea(dec_linea), .dec_linef(dec_linef), .dec_opcode(dec_opcode)
    );

    // pROM model: bypass read, output updates only on a ce edge.
    logic [35:0] rom [256];
    always @(posedge clk) if (rom_ce) rom_dout <= rom[rom_ad];

    typedef struct packed {
        logic [15:0] op;
        logic [7:0]  ad;
        logic [11:0] ua1;
        logic [11:0] ua2;
        logic [11:0] flags;
        logic        ill;
        logic        la;
        logic        lf;
    } vec_t;

    vec_t vecs [9];
    vec_t exp_q [$];
    vec_t mon_e;
    int   pop_log [$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   stall_seen = 0;

    logic        prev_hold = 1'b0;
    logic [54:0] prev_data;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold stability.
    always @(negedge clk) begin
        if (!reset && !flush && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got opcode %h required none", dec_opcode);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("entry_%h", mon_e.op),
                      {9'd0, dec_ua1, dec_ua2, dec_flags, dec_illegal, dec_linea, dec_linef, dec_opcode},
                      {9'd0, mon_e.ua1, mon_e.ua2, mon_e.flags, mon_e.ill, mon_e.la, mon_e.lf, mon_e.op});
                $display("entry op=%h ua1=%h ua2=%h flags=%h ill=%b la=%b lf=%b cycle=%0d",
                         dec_opcode, dec_ua1, dec_ua2, dec_flags, dec_illegal, dec_linea, dec_linef, cycle);
                pop_log.push_back(cycle);
            end
        end
        if (prev_hold) begin
            check("hold_stable",
                  {9'd0, dec_valid, dec_ua1, dec_ua2, dec_flags, dec_illegal, dec_linea, dec_linef, dec_opcode},
                  {9'd0, 1'b1, prev_data});
        end
        prev_hold = !reset && !flush && dec_valid && !dec_ready;
        prev_data = {dec_ua1, dec_ua2, dec_flags, dec_illegal, dec_linea, dec_linef, dec_opcode};
        if (!reset && !flush && op_valid && !op_ready) begin
            stall_seen++;
            check("stall_rom_ce", rom_ce, 1'b0);
        end
    end

    // Offer one vector until accepted; log and push the expectation on accept.
    task automatic send(input int i);
        bit acc = 0;
        int n = 0;
        opcode   = vecs[i].op;
        op_valid = 1'b1;
        while (!acc && n < 20) begin
            @(negedge clk);
            if (op_ready) begin
                acc = 1;
                check($sformatf("rom_ad_%h", vecs[i].op), rom_ad, vecs[i].ad);
                check("rom_ce_accept", rom_ce, 1'b1);
                exp_q.push_back(vecs[i]);
                $display("accept op=%h rom_ad=%h cycle=%0d", opcode, rom_ad, cycle);
            end
            @(posedge clk);
            #1;
            n++;
        end
        op_valid = 1'b0;
        if (!acc) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) rom[k] = '0;
        rom[8'h47] = 36'h0B3104300;
        rom[8'h00] = 36'h03B000000;
        rom[8'h50] = 36'h03B001000;
        rom[8'hA2] = 36'h0A10A20A3;
        rom[8'hF0] = 36'h0F10F20F3;
        rom[8'h13] = 36'h113213313;
        rom[8'h24] = 36'h124224324;
        rom[8'h35] = 36'h135235335;
        rom[8'h46] = 36'h146246346;

        //          opcode    index  ua1     ua2     flags   ill  la   lf
        vecs[0] = '{16'h4E75, 8'h47, 12'h0B3, 12'h104, 12'h300, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 8'h00, 12'h03B, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h5000, 8'h50, 12'h03B, 12'h001, 12'h000, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'hA123, 8'hA2, 12'h0A1, 12'h0A2, 12'h0A3, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'hF200, 8'hF0, 12'h0F1, 12'h0F2, 12'h0F3, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h1234, 8'h13, 12'h113, 12'h213, 12'h313, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h2345, 8'h24, 12'h124, 12'h224, 12'h324, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h3456, 8'h35, 12'h135, 12'h235, 12'h335, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h4567, 8'h46, 12'h146, 12'h246, 12'h346, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; op_valid = 1'b0; flush = 1'b0; dec_ready = 1'b1; opcode = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_op_ready", op_ready, 1'b0);
        check("reset_rom_ce", rom_ce, 1'b0);
        check("reset_rom_oce", rom_oce, 1'b1);
        check("reset_rom_reset", rom_reset, 1'b1);
        check("reset_dec", {dec_valid, dec_ua1, dec_ua2, dec_flags, dec_illegal, dec_linea, dec_linef, dec_opcode}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_op_ready", op_ready, 1'b1);
        check("post_reset_rom_reset", rom_reset, 1'b0);
        @(posedge clk); #1;

        // Basic lookup, illegal slot, near-illegal slot
        send(0);
        drain();
        send(1);
        send(2);
        drain();

        // Line A then line F, back to back
        send(3);
        send(4);
        drain();
        check("af_consecutive", pop_log[pop_log.size()-1] - pop_log[pop_log.size()-2], 1);

        // Stream of four with a three-cycle sink stall
        stall_seen = 0;
        fork
            begin
                for (int k = 5; k <= 8; k++) send(k);
            end
            begin
                @(posedge clk); #1;
                dec_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                dec_ready = 1'b1;
            end
        join
        drain();
        check("stall_observed", stall_seen != 0, 1'b1);

        // Flush with both stages full; the opcode offered alongside is refused
        dec_ready = 1'b0;
        send(5);
        send(6);
        flush = 1'b1; op_valid = 1'b1; opcode = 16'h4E75;
        @(negedge clk);
        check("flush_pre_valid", dec_valid, 1'b1);
        check("flush_op_ready", op_ready, 1'b0);
        check("flush_rom_ce", rom_ce, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        check("flush_dec_valid", dec_valid, 1'b0);
        @(negedge clk);
        check("flush_no_leak", dec_valid, 1'b0);
        @(posedge clk); #1;
        send(7);
        drain();

        // Reset in the middle of a stalled stream
        dec_ready = 1'b0;
        send(0);
        send(1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_pre_valid", dec_valid, 1'b1);
        check("mid_reset_op_ready", op_ready, 1'b0);
        check("mid_reset_rom_ce", rom_ce, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        check("mid_reset_dec", {dec_valid, dec_ua1, dec_ua2, dec_flags, dec_illegal, dec_linea, dec_linef, dec_opcode}, '0);
        check("mid_reset_op_ready_back", op_ready, 1'b1);
        @(posedge clk); #1;
        send(8);
        drain();

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
